// File: rtl/comparador_serie_ctrl_pkg.sv
// Shared definitions for the serial LSB-first comparator controller: FSM state type and counter sizing.
package comparador_serie_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Bit-index counter width; a single-bit word still needs a 1-bit counter.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/comparador_serie_ctrl_celda.sv
// One-bit iterative comparator cell, right-to-left (LSB first) evaluation.
// The eq path exists only when COMPARADOR_EQ_EN is defined.
module comparador_celda (
    input  logic a,
    input  logic b,
    input  logic gt_in,
`ifdef COMPARADOR_EQ_EN
    input  logic eq_in,
    output logic eq_out,
`endif
    output logic gt_out
);

    // A more significant bit overrides; equal bits pass the lower-order verdict through.
    assign gt_out = (a & ~b) | (~(a ^ b) & gt_in);

`ifdef COMPARADOR_EQ_EN
    assign eq_out = eq_in & ~(a ^ b);
`endif

endmodule

// File: rtl/comparador_serie_ctrl.sv
// Serial A > B comparator: captures A/B on start, steps one shared cell per clock, LSB first.
// Optional equality output enabled by defining COMPARADOR_EQ_EN.
module comparador_serie_ctrl
    import comparador_serie_ctrl_pkg::*;
#(
    parameter int unsigned N = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] A,
    input  logic [N-1:0] B,
    output logic         busy,
    output logic         done,
`ifdef COMPARADOR_EQ_EN
    output logic         eq_out,
`endif
    output logic         W_out
);

    localparam int unsigned    CW   = cnt_width(N);
    localparam logic [CW-1:0]  LAST = CW'(N - 1);

    state_t        state_q, state_d;
    logic [N-1:0]  sa_q, sa_d;
    logic [N-1:0]  sb_q, sb_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          gt_q, gt_d;
    logic          w_q, w_d;
    logic          cell_gt;
`ifdef COMPARADOR_EQ_EN
    logic          eq_q, eq_d;
    logic          eqo_q, eqo_d;
    logic          cell_eq;
`endif

    comparador_celda u_celda (
        .a      (sa_q[0]),
        .b      (sb_q[0]),
        .gt_in  (gt_q),
`ifdef COMPARADOR_EQ_EN
        .eq_in  (eq_q),
        .eq_out (cell_eq),
`endif
        .gt_out (cell_gt)
    );

    always_comb begin
        state_d = state_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        cnt_d   = cnt_q;
        gt_d    = gt_q;
        w_d     = w_q;
`ifdef COMPARADOR_EQ_EN
        eq_d    = eq_q;
        eqo_d   = eqo_q;
`endif
        busy    = (state_q == ST_RUN);
        done    = (state_q == ST_DONE);

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    sa_d    = A;
                    sb_d    = B;
                    gt_d    = 1'b0;
                    cnt_d   = '0;
`ifdef COMPARADOR_EQ_EN
                    eq_d    = 1'b1;
`endif
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                gt_d = cell_gt;
                sa_d = sa_q >> 1;
                sb_d = sb_q >> 1;
`ifdef COMPARADOR_EQ_EN
                eq_d = cell_eq;
`endif
                // Counter holds on the last bit instead of wrapping.
                if (cnt_q == LAST) begin
                    w_d     = cell_gt;
`ifdef COMPARADOR_EQ_EN
                    eqo_d   = cell_eq;
`endif
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            cnt_q   <= '0;
            gt_q    <= 1'b0;
            w_q     <= 1'b0;
`ifdef COMPARADOR_EQ_EN
            eq_q    <= 1'b0;
            eqo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            cnt_q   <= cnt_d;
            gt_q    <= gt_d;
            w_q     <= w_d;
`ifdef COMPARADOR_EQ_EN
            eq_q    <= eq_d;
            eqo_q   <= eqo_d;
`endif
        end
    end

    assign W_out = w_q;
`ifdef COMPARADOR_EQ_EN
    assign eq_out = eqo_q;
`endif

endmodule

// File: tb/tb_comparador_serie_ctrl.sv
// Bench for comparador_serie_ctrl (N=8 and N=1 instances); eq_out checks follow COMPARADOR_EQ_EN.
module tb_comparador_serie_ctrl;

    logic       clk = 1'b0;
    logic       reset, start, start1;
    logic [7:0] A, B;
    logic [0:0] A1, B1;
    logic       busy, done, W_out;
    logic       busy1, done1, W1;
`ifdef COMPARADOR_EQ_EN
    logic       eq_out, eq1;
`endif

    int total = 0;
    int bad   = 0;
    logic prev_w = 1'b0;

    always #5 clk = ~clk;

    comparador_serie_ctrl #(.N(8)) dut8 (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .done   (done),
`ifdef COMPARADOR_EQ_EN
        .eq_out (eq_out),
`endif
        .W_out  (W_out)
    );

    comparador_serie_ctrl #(.N(1)) dut1 (
        .clk    (clk),
        .reset  (reset),
        .start  (start1),
        .A      (A1),
        .B      (B1),
        .busy   (busy1),
        .done   (done1),
`ifdef COMPARADOR_EQ_EN
        .eq_out (eq1),
`endif
        .W_out  (W1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full comparison; result expected from plain unsigned arithmetic.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input bit hold, input string tag);
        logic exp_w;
        exp_w = (a > b);
        A = a;
        B = b;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        for (int i = 0; i < 8; i++) begin
            chk({tag, ".busy"}, busy, 1);
            chk({tag, ".nodone"}, done, 0);
            chk({tag, ".wheld"}, W_out, prev_w);
            tick();
        end
        chk({tag, ".done"}, done, 1);
        chk({tag, ".busy_end"}, busy, 0);
        chk({tag, ".w"}, W_out, exp_w);
`ifdef COMPARADOR_EQ_EN
        chk({tag, ".eq"}, eq_out, (a == b));
`endif
        prev_w = exp_w;
        tick();
        chk({tag, ".done_pulse"}, done, 0);
        chk({tag, ".idle"}, busy, 0);
        chk({tag, ".w_keep"}, W_out, exp_w);
    endtask

    initial begin
        int dones;
        logic [7:0] ra, rb;

        reset = 1'b1; start = 1'b0; start1 = 1'b0;
        A = '0; B = '0; A1 = '0; B1 = '0;
        tick();
        tick();
        reset = 1'b0;
        chk("rst.busy", busy, 0);
        chk("rst.done", done, 0);
        chk("rst.w", W_out, 0);
        chk("rst1.busy", busy1, 0);
        chk("rst1.w", W1, 0);
`ifdef COMPARADOR_EQ_EN
        chk("rst.eq", eq_out, 0);
`endif

        run8(8'hA5, 8'h5A, 1'b0, "a5_5a");
        run8(8'h3C, 8'h3C, 1'b0, "eq3c");
        run8(8'h01, 8'h80, 1'b0, "msb");
        run8(8'hFF, 8'h00, 1'b0, "max");

        // Second start during RUN must be ignored.
        A = 8'hF0; B = 8'h0F; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        A = 8'h00; B = 8'hFF; start = 1'b1;
        tick();
        start = 1'b0;
        dones = 0;
        for (int i = 0; i < 14; i++) begin
            if (done) begin
                dones++;
                chk("ign.w", W_out, 1);
            end
            tick();
        end
        chk("ign.ndone", dones, 1);
        prev_w = 1'b1;

        // Reset in the 4th RUN cycle aborts the operation.
        A = 8'hFF; B = 8'h00; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("abort.busy_pre", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort.busy", busy, 0);
        chk("abort.done", done, 0);
        chk("abort.w", W_out, 0);
        prev_w = 1'b0;
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            if (done) dones++;
            tick();
        end
        chk("abort.ndone", dones, 0);

        // N=1 instance: every operand combination.
        for (int unsigned k = 0; k < 4; k++) begin
            A1 = (k >= 2) ? 1'b1 : 1'b0;
            B1 = (k % 2 == 1) ? 1'b1 : 1'b0;
            start1 = 1'b1;
            tick();
            start1 = 1'b0;
            chk("n1.busy", busy1, 1);
            chk("n1.nodone", done1, 0);
            tick();
            chk("n1.done", done1, 1);
            chk("n1.w", W1, (k == 2) ? 1 : 0);
`ifdef COMPARADOR_EQ_EN
            chk("n1.eq", eq1, (k == 0 || k == 3) ? 1 : 0);
`endif
            tick();
            chk("n1.done_pulse", done1, 0);
        end

        // Random pairs with start held high: back-to-back every N+2 cycles.
        for (int n = 0; n < 200; n++) begin
            ra = 8'($urandom_range(0, (1 << 8) - 1));
            rb = 8'($urandom_range(0, (1 << 8) - 1));
            if (n % 16 == 0) rb = ra;
            run8(ra, rb, 1'b1, "rand");
        end
        start = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
